dec38_strobe: RTL and testbench

DEC38_STROBE -- requirements
Module: dec38_strobe

---
 rtl/dec38_strobe.sv | 130 +++++++++++++
 tb/tb_dec38_strobe.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/dec38_strobe.sv
// dec38_strobe: 3-to-8 one-hot decoder that emits each accepted code as a
// fixed-length strobe followed by an optional all-zero gap, with a saturating
// count of accepted codes.
module dec38_strobe #(
    parameter int unsigned PULSE_LEN = 4,   // cycles a decoded word is driven, 1..255
    parameter int unsigned GAP_LEN   = 1    // all-zero cycles after each pulse, 0..255
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    input  logic [2:0] din,
    input  logic       din_valid,
    output logic       din_ready,
    output logic [7:0] dout,
    output logic       dout_valid,
    output logic       busy,
    output logic [7:0] acc_cnt
);

    localparam int unsigned CNT_W = 8;

    // Counter reload values: the counter holds "cycles remaining minus one"
    // so that a value of zero marks the last cycle of the phase.
    localparam logic [CNT_W-1:0] LP_PULSE_LD = CNT_W'(PULSE_LEN - 32'd1);
    localparam logic [CNT_W-1:0] LP_GAP_LD   = (GAP_LEN != 32'd0) ? CNT_W'(GAP_LEN - 32'd1)
                                                                   : '0;
    localparam bit               LP_HAS_GAP  = (GAP_LEN != 32'd0);
    localparam logic [CNT_W-1:0] LP_ACC_MAX  = '1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DRIVE = 2'd1,
        ST_GAP   = 2'd2
    } state_t;

    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [7:0]       r_dout;
    logic             r_dout_valid;
    logic             r_busy;
    logic [7:0]       r_acc_cnt;

    logic             w_ready;
    logic             w_hs;
    logic [7:0]       w_onehot;
    logic             w_cnt_last;

    // Ready comes only from registered state and en, never from din_valid.
    assign w_ready    = en && (r_state == ST_IDLE);
    assign w_hs       = w_ready && din_valid;
    assign w_onehot   = 8'b0000_0001 << din;
    assign w_cnt_last = (r_cnt == '0);

    // Strobe FSM: reset beats enable, enable beats everything else.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state      <= ST_IDLE;
            r_cnt        <= '0;
            r_dout       <= 8'h00;
            r_dout_valid <= 1'b0;
            r_busy       <= 1'b0;
        end else if (!en) begin
            r_state      <= ST_IDLE;
            r_cnt        <= '0;
            r_dout       <= 8'h00;
            r_dout_valid <= 1'b0;
            r_busy       <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_hs) begin
                        r_state      <= ST_DRIVE;
                        r_cnt        <= LP_PULSE_LD;
                        r_dout       <= w_onehot;
                        r_dout_valid <= 1'b1;
                        r_busy       <= 1'b1;
                    end
                end
                ST_DRIVE: begin
                    if (w_cnt_last) begin
                        r_dout       <= 8'h00;
                        r_dout_valid <= 1'b0;
                        if (LP_HAS_GAP) begin
                            r_state <= ST_GAP;
                            r_cnt   <= LP_GAP_LD;
                            r_busy  <= 1'b1;
                        end else begin
                            r_state <= ST_IDLE;
                            r_cnt   <= '0;
                            r_busy  <= 1'b0;
                        end
                    end else begin
                        r_cnt <= r_cnt - CNT_W'(1);
                    end
                end
                ST_GAP: begin
                    if (w_cnt_last) begin
                        r_state <= ST_IDLE;
                        r_busy  <= 1'b0;
                    end else begin
                        r_cnt <= r_cnt - CNT_W'(1);
                    end
                end
                default: begin
                    r_state      <= ST_IDLE;
                    r_cnt        <= '0;
                    r_dout       <= 8'h00;
                    r_dout_valid <= 1'b0;
                    r_busy       <= 1'b0;
                end
            endcase
        end
    end

    // Saturating count of accepted codes; en does not clear it.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_acc_cnt <= 8'h00;
        end else if (w_hs && (r_acc_cnt != LP_ACC_MAX)) begin
            r_acc_cnt <= r_acc_cnt + 8'd1;
        end
    end

    assign din_ready  = w_ready;
    assign dout       = r_dout;
    assign dout_valid = r_dout_valid;
    assign busy       = r_busy;
    assign acc_cnt    = r_acc_cnt;

endmodule

// File: tb/tb_dec38_strobe.sv
// Testbench for dec38_strobe: three parameter sets share one stimulus stream
// and are each compared against a timeline model of accepted codes.
module tb_dec38_strobe;

    localparam int NCFG = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n;
    logic       en;
    logic [2:0] din;
    logic       din_valid;

    logic [NCFG-1:0]      w_ready;
    logic [NCFG-1:0]      w_dval;
    logic [NCFG-1:0]      w_busy;
    logic [NCFG-1:0][7:0] w_dout;
    logic [NCFG-1:0][7:0] w_acc;

    dec38_strobe #(.PULSE_LEN(4), .GAP_LEN(1)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .en(en), .din(din), .din_valid(din_valid),
        .din_ready(w_ready[0]), .dout(w_dout[0]), .dout_valid(w_dval[0]),
        .busy(w_busy[0]), .acc_cnt(w_acc[0]));

    dec38_strobe #(.PULSE_LEN(1), .GAP_LEN(0)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .en(en), .din(din), .din_valid(din_valid),
        .din_ready(w_ready[1]), .dout(w_dout[1]), .dout_valid(w_dval[1]),
        .busy(w_busy[1]), .acc_cnt(w_acc[1]));

    dec38_strobe #(.PULSE_LEN(3), .GAP_LEN(2)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .en(en), .din(din), .din_valid(din_valid),
        .din_ready(w_ready[2]), .dout(w_dout[2]), .dout_valid(w_dval[2]),
        .busy(w_busy[2]), .acc_cnt(w_acc[2]));

    int n_cmp = 0;
    int n_err = 0;

    // Model: each config remembers only when its last code was accepted.
    longint     n_edge = 0;
    bit         m_active [NCFG];
    longint     m_t_acc  [NCFG];
    logic [2:0] m_code   [NCFG];
    int         m_acc    [NCFG];

    function automatic int cfg_p(input int i);
        case (i)
            0:       return 4;
            1:       return 1;
            default: return 3;
        endcase
    endfunction

    function automatic int cfg_g(input int i);
        case (i)
            0:       return 1;
            1:       return 0;
            default: return 2;
        endcase
    endfunction

    function automatic bit m_busy(input int i);
        return m_active[i] && ((n_edge - m_t_acc[i]) < longint'(cfg_p(i) + cfg_g(i)));
    endfunction

    function automatic bit m_pulse(input int i);
        return m_active[i] && ((n_edge - m_t_acc[i]) < longint'(cfg_p(i)));
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s @edge %0d: got %0h, expected %0h", tag, n_edge, got, exp);
        end
    endtask

    // One clock cycle: drive inputs, check ready, advance model, check outputs.
    task automatic step(input bit r, input bit e, input bit dv, input logic [2:0] d);
        bit   exp_rdy [NCFG];
        logic [7:0] exp_dout;
        @(negedge clk);
        rst_n     = r;
        en        = e;
        din_valid = dv;
        din       = d;
        #1;
        for (int i = 0; i < NCFG; i++) begin
            exp_rdy[i] = e && !m_busy(i);
            check($sformatf("ready%0d", i), 32'(w_ready[i]), 32'(exp_rdy[i]));
        end
        @(posedge clk);
        n_edge++;
        for (int i = 0; i < NCFG; i++) begin
            if (!r) begin
                m_active[i] = 1'b0;
                m_acc[i]    = 0;
            end else if (!e) begin
                m_active[i] = 1'b0;
            end else if (exp_rdy[i] && dv) begin
                m_active[i] = 1'b1;
                m_t_acc[i]  = n_edge;
                m_code[i]   = d;
                if (m_acc[i] < 255) m_acc[i]++;
            end
        end
        #1;
        for (int i = 0; i < NCFG; i++) begin
            exp_dout = m_pulse(i) ? (8'h01 << m_code[i]) : 8'h00;
            check($sformatf("dout%0d", i),  32'(w_dout[i]), 32'(exp_dout));
            check($sformatf("dval%0d", i),  32'(w_dval[i]), 32'(m_pulse(i)));
            check($sformatf("busy%0d", i),  32'(w_busy[i]), 32'(m_busy(i)));
            check($sformatf("acc%0d", i),   32'(w_acc[i]),  32'(m_acc[i]));
        end
    endtask

    task automatic idle_steps(input int k);
        for (int j = 0; j < k; j++) step(1'b1, 1'b1, 1'b0, 3'($urandom_range(7)));
    endtask

    initial begin
        for (int i = 0; i < NCFG; i++) begin
            m_active[i] = 1'b0;
            m_t_acc[i]  = 0;
            m_code[i]   = 3'd0;
            m_acc[i]    = 0;
        end
        rst_n = 1'b0; en = 1'b0; din = 3'd0; din_valid = 1'b0;

        // Reset with enable low, then release.
        step(1'b0, 1'b0, 1'b0, 3'd0);
        step(1'b0, 1'b1, 1'b1, 3'd3);

        // Single code 5 with default timing, then idle.
        step(1'b1, 1'b1, 1'b1, 3'd5);
        idle_steps(8);

        // Back-to-back sweep of all codes with din_valid held high.
        for (int d = 0; d < 8; d++)
            for (int j = 0; j < 6; j++) step(1'b1, 1'b1, 1'b1, 3'(d));
        idle_steps(8);

        // Enable dropped on the second drive cycle of code 7.
        step(1'b1, 1'b1, 1'b1, 3'd7);
        step(1'b1, 1'b1, 1'b0, 3'd7);
        for (int j = 0; j < 4; j++) step(1'b1, 1'b0, 1'b1, 3'd7);
        idle_steps(8);

        // Reset pulse in the gap of the default config, then immediate accept.
        step(1'b1, 1'b1, 1'b1, 3'd2);
        idle_steps(4);
        step(1'b0, 1'b1, 1'b1, 3'd4);
        step(1'b1, 1'b1, 1'b1, 3'd6);
        idle_steps(8);

        // din_valid with enable low: no accepts.
        for (int j = 0; j < 10; j++) step(1'b1, 1'b0, 1'b1, 3'($urandom_range(7)));

        // Continuous offers long enough to saturate the short-pulse config.
        for (int j = 0; j < 700; j++) step(1'b1, 1'b1, 1'b1, 3'($urandom_range(7)));
        idle_steps(8);

        // Random traffic with occasional reset and enable drops.
        for (int j = 0; j < 3000; j++)
            step($urandom_range(99) != 0, $urandom_range(19) != 0,
                 $urandom_range(2) != 0, 3'($urandom_range(7)));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
